sleep_cycle_fsm: RTL and testbench

- Downstream consumer of the sleep regulator's wake_up_signal / sleep_in_signal.
- Converts these combinational requests into a debounced, time-qualified sleep state.
- Drives the is_asleep bit, which the action vector feeds back as action[0].
- Adds drowsiness hysteresis, a minimum sleep duration, a waking transition and sleep-length bookkeeping; all timing is counted in tick enables.

---
 rtl/sleep_pkg.sv | 23 ++
 rtl/sleep_cycle_fsm_sat_counter.sv | 44 ++++
 rtl/sleep_cycle_fsm.sv | 194 +++++++++++++++++++
 tb/tb_sleep_cycle_fsm.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sleep_pkg.sv
// sleep_pkg: shared definitions for the sleep cycle controller.
//   sleep_state_e   2-bit sleep phase encoding, also driven out as sleep_phase
//   SLEEP_TIME_W    width of the sleep length counter
//   DEBT_W/DEBT_MAX width and saturation value of the sleep debt counter
//   is_sleeping()   true in the phases where is_asleep is set
package sleep_pkg;

    typedef enum logic [1:0] {
        AWAKE  = 2'd0,
        DROWSY = 2'd1,
        ASLEEP = 2'd2,
        WAKING = 2'd3
    } sleep_state_e;

    localparam int SLEEP_TIME_W = 8;
    localparam int DEBT_W       = 8;
    localparam logic [DEBT_W-1:0] DEBT_MAX = 8'd255;

    function automatic logic is_sleeping(input sleep_state_e s);
        return (s == ASLEEP) || (s == WAKING);
    endfunction

endpackage

// File: rtl/sleep_cycle_fsm_sat_counter.sv
// sat_counter: width-parameterised saturating up/down counter.
//   clk    system clock
//   rst    synchronous active-high reset, clears the count
//   clr    synchronous clear, wins over en
//   en     count enable
//   up     direction when enabled: 1 = increment (stop at all-ones), 0 = decrement (stop at 0)
//   count  registered count value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (up) begin
                if (count_q != CNT_MAX) count_d = count_q + 1'b1;
            end else begin
                if (count_q != '0) count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/sleep_cycle_fsm.sv
// sleep_cycle_fsm: turns the regulator's sleep/wake requests into a debounced,
// time-qualified sleep state with hysteresis, minimum sleep time and a waking phase.
// Build option: define SLEEP_DEBT_EN to add the sleep debt accumulator; otherwise
// sleep_debt is tied to 0.
//   clk                system clock
//   rst                synchronous active-high reset
//   tick               one-clk time-base enable; all counting advances on it
//   sleep_in_signal    request to fall asleep
//   wake_up_signal     request to wake
//   vital_energy_zero  forces immediate collapse into sleep from AWAKE/DROWSY
//   is_asleep          set in ASLEEP and WAKING (feeds action[0])
//   sleep_phase        current phase, see table below
//   sleep_time         ticks spent in the current/last sleep
//   sleep_event        one-clk pulse on entry to ASLEEP from AWAKE/DROWSY
//   wake_event         one-clk pulse on WAKING -> AWAKE
//   sleep_debt         accumulated sleep debt
//
// state  | meaning
// AWAKE  | awake, watching for sustained sleep_in_signal
// DROWSY | sleep_in_signal seen, counting consecutive ticks toward sleep
// ASLEEP | asleep, sleep_time counting, wake ignored until minimum met
// WAKING | wake requested, needs WAKE_TICKS consecutive wake ticks
module sleep_cycle_fsm
    import sleep_pkg::*;
#(
    parameter int DROWSY_TICKS    = 4,
    parameter int MIN_SLEEP_TICKS = 16,
    parameter int WAKE_TICKS      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    sleep_in_signal,
    input  logic                    wake_up_signal,
    input  logic                    vital_energy_zero,
    output logic                    is_asleep,
    output logic [1:0]              sleep_phase,
    output logic [SLEEP_TIME_W-1:0] sleep_time,
    output logic                    sleep_event,
    output logic                    wake_event,
    output logic [DEBT_W-1:0]       sleep_debt
);

    localparam logic [3:0] DROWSY_LOAD = 4'(DROWSY_TICKS - 1);
    localparam logic [3:0] WAKE_LOAD   = 4'(WAKE_TICKS);
    localparam logic [SLEEP_TIME_W-1:0] MIN_SLEEP = SLEEP_TIME_W'(MIN_SLEEP_TICKS);

    sleep_state_e state_q, state_d;
    logic [3:0]   drowsy_left_q, drowsy_left_d;
    logic [3:0]   wake_left_q, wake_left_d;
    logic         is_asleep_q, is_asleep_d;
    logic         sleep_event_q, sleep_event_d;
    logic         wake_event_q, wake_event_d;
    logic         asleep_entry;
    logic         time_en;
    logic         debt_full;
    logic         force_sleep;
    logic [SLEEP_TIME_W-1:0] sleep_time_q;

    assign force_sleep = vital_energy_zero | debt_full;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= AWAKE;
            drowsy_left_q <= '0;
            wake_left_q   <= '0;
        end else begin
            state_q       <= state_d;
            drowsy_left_q <= drowsy_left_d;
            wake_left_q   <= wake_left_d;
        end
    end

    // Next state; drowsy/wake timers are down-counters ending at terminal count 1
    always_comb begin
        state_d       = state_q;
        drowsy_left_d = drowsy_left_q;
        wake_left_d   = wake_left_q;
        case (state_q)
            AWAKE: begin
                if (force_sleep) begin
                    state_d = ASLEEP;
                end else if (tick && sleep_in_signal) begin
                    if (DROWSY_LOAD == 4'd0) begin
                        state_d = ASLEEP;
                    end else begin
                        state_d       = DROWSY;
                        drowsy_left_d = DROWSY_LOAD;
                    end
                end
            end
            DROWSY: begin
                if (force_sleep) begin
                    state_d = ASLEEP;
                end else if (tick) begin
                    if (!sleep_in_signal)          state_d = AWAKE;
                    else if (drowsy_left_q <= 4'd1) state_d = ASLEEP;
                    else                           drowsy_left_d = drowsy_left_q - 4'd1;
                end
            end
            ASLEEP: begin
                // threshold uses the count before this tick's increment
                if (tick && wake_up_signal && (sleep_time_q >= MIN_SLEEP)) begin
                    state_d     = WAKING;
                    wake_left_d = WAKE_LOAD;
                end
            end
            WAKING: begin
                if (tick) begin
                    if (!wake_up_signal)          state_d = ASLEEP;
                    else if (wake_left_q <= 4'd1) state_d = AWAKE;
                    else                          wake_left_d = wake_left_q - 4'd1;
                end
            end
            default: state_d = AWAKE;
        endcase
        if (state_d != DROWSY) drowsy_left_d = '0;
        if (state_d != WAKING) wake_left_d   = '0;
    end

    // Outputs; dozing back from WAKING is not a new sleep
    always_comb begin
        asleep_entry  = (state_d == ASLEEP) && !is_sleeping(state_q);
        is_asleep_d   = is_sleeping(state_d);
        sleep_event_d = asleep_entry;
        wake_event_d  = (state_q == WAKING) && (state_d == AWAKE);
        time_en       = tick && is_sleeping(state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_asleep_q   <= 1'b0;
            sleep_event_q <= 1'b0;
            wake_event_q  <= 1'b0;
        end else begin
            is_asleep_q   <= is_asleep_d;
            sleep_event_q <= sleep_event_d;
            wake_event_q  <= wake_event_d;
        end
    end

    sat_counter #(.W(SLEEP_TIME_W)) u_sleep_time (
        .clk   (clk),
        .rst   (rst),
        .clr   (asleep_entry),
        .en    (time_en),
        .up    (1'b1),
        .count (sleep_time_q)
    );

`ifdef SLEEP_DEBT_EN
    logic              parity_q, parity_d;
    logic              debt_en;
    logic              debt_up;
    logic [DEBT_W-1:0] debt_q;

    // While sleeping, parity marks every second tick for a decrement
    always_comb begin
        parity_d = parity_q;
        if (asleep_entry)                        parity_d = 1'b0;
        else if (tick && is_sleeping(state_q))   parity_d = ~parity_q;
        debt_up = !is_sleeping(state_q);
        debt_en = tick && (debt_up || parity_q);
    end

    always_ff @(posedge clk) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end

    sat_counter #(.W(DEBT_W)) u_sleep_debt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (debt_en),
        .up    (debt_up),
        .count (debt_q)
    );

    assign debt_full  = (debt_q == DEBT_MAX);
    assign sleep_debt = debt_q;
`else
    assign debt_full  = 1'b0;
    assign sleep_debt = '0;
`endif

    assign is_asleep   = is_asleep_q;
    assign sleep_phase = state_q;
    assign sleep_time  = sleep_time_q;
    assign sleep_event = sleep_event_q;
    assign wake_event  = wake_event_q;

endmodule

// File: tb/tb_sleep_cycle_fsm.sv
module tb_sleep_cycle_fsm;

    localparam int DT = 4;
    localparam int MS = 16;
    localparam int WT = 2;
`ifdef SLEEP_DEBT_EN
    localparam bit DEBT_EN = 1'b1;
`else
    localparam bit DEBT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, tick, sin, wu, vez;
    logic       is_asleep, sleep_event, wake_event;
    logic [1:0] sleep_phase;
    logic [7:0] sleep_time, sleep_debt;

    always #5 clk = ~clk;

    sleep_cycle_fsm #(
        .DROWSY_TICKS(DT), .MIN_SLEEP_TICKS(MS), .WAKE_TICKS(WT)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .sleep_in_signal(sin),
        .wake_up_signal(wu), .vital_energy_zero(vez), .is_asleep(is_asleep),
        .sleep_phase(sleep_phase), .sleep_time(sleep_time), .sleep_event(sleep_event),
        .wake_event(wake_event), .sleep_debt(sleep_debt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase names 0..3, up-counting tick tallies as described
    int m_phase, m_dcnt, m_wcnt, m_st, m_debt, m_par, m_sev, m_wev;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit t, input bit s, input bit w, input bit v);
        int  nxt;
        bit  sleeping_before, forced;
        if (r) begin
            m_phase = 0; m_dcnt = 0; m_wcnt = 0; m_st = 0;
            m_debt = 0; m_par = 0; m_sev = 0; m_wev = 0;
            return;
        end
        nxt = m_phase;
        m_sev = 0;
        m_wev = 0;
        forced = v || (DEBT_EN && m_debt == 255);
        sleeping_before = (m_phase >= 2);
        case (m_phase)
            0: if (forced) nxt = 2;
               else if (t && s) begin
                   m_dcnt = 1;
                   nxt = (m_dcnt >= DT) ? 2 : 1;
               end
            1: if (forced) nxt = 2;
               else if (t) begin
                   if (s) begin
                       m_dcnt++;
                       if (m_dcnt == DT) nxt = 2;
                   end else begin
                       m_dcnt = 0;
                       nxt = 0;
                   end
               end
            2: if (t && w && m_st >= MS) begin
                   nxt = 3;
                   m_wcnt = 0;
               end
            default: if (t) begin
                   if (w) begin
                       m_wcnt++;
                       if (m_wcnt == WT) begin
                           nxt = 0;
                           m_wev = 1;
                       end
                   end else nxt = 2;
               end
        endcase
        if (sleeping_before && t && m_st < 255) m_st++;
        if (DEBT_EN && t) begin
            if (!sleeping_before) begin
                if (m_debt < 255) m_debt++;
            end else begin
                if (m_par == 1 && m_debt > 0) m_debt--;
                m_par = 1 - m_par;
            end
        end
        if (nxt == 2 && !sleeping_before) begin
            m_st = 0;
            m_sev = 1;
            m_par = 0;
        end
        if (nxt != 1) m_dcnt = 0;
        m_phase = nxt;
    endtask

    task automatic cyc(input bit r, input bit t, input bit s, input bit w, input bit v);
        rst = r; tick = t; sin = s; wu = w; vez = v;
        @(posedge clk);
        model_step(r, t, s, w, v);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".phase"}, int'(sleep_phase), m_phase);
        chk({tag, ".asleep"}, int'(is_asleep), (m_phase >= 2) ? 1 : 0);
        chk({tag, ".sleep_time"}, int'(sleep_time), m_st);
        chk({tag, ".sleep_event"}, int'(sleep_event), m_sev);
        chk({tag, ".wake_event"}, int'(wake_event), m_wev);
        chk({tag, ".debt"}, int'(sleep_debt), m_debt);
    endtask

    typedef struct {
        bit r, t, s, w, v;
        int ph;
        int sl;
        int sev;
        int wev;
        int st;
    } vec_t;

    vec_t tbl[12];

    initial begin
        rst = 1'b1; tick = 1'b0; sin = 1'b0; wu = 1'b0; vez = 1'b0;
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        //              r  t  s  w  v   ph sl sev wev st
        tbl[0]  = '{1, 1, 1, 1, 1,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 0,  2, 1, 1, 0, 0};
        tbl[5]  = '{0, 0, 1, 1, 0,  2, 1, 0, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 1,  2, 1, 1, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 0,  2, 1, 0, 0, 1};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].w, tbl[i].v);
            chk($sformatf("vec%0d.phase", i), int'(sleep_phase), tbl[i].ph);
            chk($sformatf("vec%0d.asleep", i), int'(is_asleep), tbl[i].sl);
            chk($sformatf("vec%0d.sleep_event", i), int'(sleep_event), tbl[i].sev);
            chk($sformatf("vec%0d.wake_event", i), int'(wake_event), tbl[i].wev);
            chk($sformatf("vec%0d.sleep_time", i), int'(sleep_time), tbl[i].st);
        end

        // Minimum sleep then waking: WAKING after tick 17, awake after tick 19
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("wake.entry_phase", int'(sleep_phase), 2);
        for (int k = 1; k <= 19; k++) begin
            cyc(0, 1, 0, 1, 0);
            chk($sformatf("wake.k%0d.phase", k), int'(sleep_phase), (k <= 16) ? 2 : ((k < 19) ? 3 : 0));
            chk($sformatf("wake.k%0d.sleep_time", k), int'(sleep_time), k);
            chk($sformatf("wake.k%0d.wake_event", k), int'(wake_event), (k == 19) ? 1 : 0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, k[0], 0, 0, 0);
            chk("wake.hold_time", int'(sleep_time), 19);
            chk("wake.hold_phase", int'(sleep_phase), 0);
            chk("wake.pulse_gone", int'(wake_event), 0);
        end

        // Doze back from WAKING without clearing sleep_time
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        for (int k = 1; k <= 17; k++) cyc(0, 1, 0, 1, 0);
        chk("doze.waking", int'(sleep_phase), 3);
        cyc(0, 1, 0, 0, 0);
        chk("doze.phase", int'(sleep_phase), 2);
        chk("doze.sleep_time", int'(sleep_time), 18);
        chk("doze.no_event", int'(sleep_event), 0);
        chk("doze.asleep", int'(is_asleep), 1);
        cyc(0, 1, 0, 1, 0);
        chk("doze.rewake", int'(sleep_phase), 3);
        chk("doze.rewake_time", int'(sleep_time), 19);

        // sleep_time saturates at 255
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        for (int k = 0; k < 260; k++) cyc(0, 1, 0, 0, 0);
        chk("sat.sleep_time", int'(sleep_time), 255);
        chk("sat.phase", int'(sleep_phase), 2);

        // Sleep debt
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 255; k++) cyc(0, 1, 0, 0, 0);
        chk("debt.awake_phase", int'(sleep_phase), 0);
        chk("debt.full", int'(sleep_debt), DEBT_EN ? 255 : 0);
        cyc(0, 0, 0, 0, 0);
        chk("debt.forced_phase", int'(sleep_phase), DEBT_EN ? 2 : 0);
        chk("debt.forced_event", int'(sleep_event), DEBT_EN ? 1 : 0);
        for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0, 0);
        chk("debt.after_sleep", int'(sleep_debt), DEBT_EN ? 245 : 0);

        // Randomised run against the model
        cyc(1, 0, 0, 0, 0);
        check_model("rnd.reset");
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom % 700) == 0,
                ($urandom % 3) != 0,
                ($urandom % 4) != 0,
                ($urandom % 10) < 7,
                ($urandom % 80) == 0);
            check_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
